// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// Module : exec_unit
// Execute stage: single-cycle RV32I ALU plus an iterative RV32M mul/div unit
// behind valid/ready handshakes on both sides.
// Rev    : 1.0  initial release
// ============================================================================
module exec_unit #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] pass_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y_o,
  output logic [XLEN-1:0] pass_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int               c_shamt_w  = $clog2(XLEN);
  localparam logic [c_shamt_w-1:0] c_cnt_last = c_shamt_w'(XLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULDIV = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic                 w_accept, w_is_alu, w_is_m;
  logic [c_shamt_w-1:0] w_shamt;
  logic [XLEN-1:0]      w_alu_y;

  assign in_ready = (r_state == ST_IDLE) && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign busy_o   = (r_state == ST_MULDIV);
  assign w_is_alu = (op_i <= 5'd10);
  assign w_is_m   = (ENABLE_M != 0) && (op_i[4:3] == 2'b10);
  assign w_shamt  = b_i[c_shamt_w-1:0];

  always_comb begin
    w_alu_y = '0;
    case (op_i)
      5'd0, 5'd10: w_alu_y = a_i + b_i;
      5'd1:        w_alu_y = a_i - b_i;
      5'd2:        w_alu_y = a_i << w_shamt;
      5'd3:        w_alu_y = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      5'd4:        w_alu_y = {{(XLEN-1){1'b0}}, a_i < b_i};
      5'd5:        w_alu_y = a_i ^ b_i;
      5'd6:        w_alu_y = a_i >> w_shamt;
      5'd7:        w_alu_y = $signed(a_i) >>> w_shamt;
      5'd8:        w_alu_y = a_i | b_i;
      5'd9:        w_alu_y = a_i & b_i;
      default:     w_alu_y = '0;
    endcase
  end

  // Operand preparation: magnitudes plus the sign flags the op needs.
  logic            w_div_op, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;

  assign w_div_op   = op_i[2];
  assign w_a_signed = w_div_op ? !op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
  assign w_b_signed = w_div_op ? !op_i[0] : (op_i[1:0] == 2'b01);
  assign w_a_neg    = w_a_signed && a_i[XLEN-1];
  assign w_b_neg    = w_b_signed && b_i[XLEN-1];
  assign w_a_mag    = w_a_neg ? -a_i : a_i;
  assign w_b_mag    = w_b_neg ? -b_i : b_i;

  logic [XLEN-1:0]      r_hi, r_lo, r_mcand;
  logic [c_shamt_w-1:0] r_cnt;
  logic                 r_is_div, r_sel, r_neg_main, r_neg_rem;

  // Multiply keeps {acc, multiplier} in {r_hi, r_lo}; divide keeps {rem, quotient}.
  logic [XLEN:0] w_mul_acc, w_div_shift, w_div_diff;

  assign w_mul_acc   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_mcand}) : {1'b0, r_hi};
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_mcand};

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_md_y;

  assign w_prod = r_neg_main ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo  = r_neg_main ? -r_lo : r_lo;
  assign w_rem  = r_neg_rem  ? -r_hi : r_hi;
  assign w_md_y = r_is_div ? (r_sel ? w_rem : w_quo)
                           : (r_sel ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && w_is_m) w_state_nxt = ST_MULDIV;
      ST_MULDIV: if (r_cnt == c_cnt_last) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_o        <= '0;
      pass_o     <= '0;
      out_valid  <= 1'b0;
      illegal_o  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mcand    <= '0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_sel      <= 1'b0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
    end else begin
      if (w_accept) pass_o <= pass_i;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_m) begin
              out_valid  <= 1'b0;
              r_cnt      <= '0;
              r_hi       <= '0;
              r_lo       <= w_div_op ? w_a_mag : w_b_mag;
              r_mcand    <= w_div_op ? w_b_mag : w_a_mag;
              r_is_div   <= w_div_op;
              r_sel      <= w_div_op ? op_i[1] : (op_i[1:0] != 2'b00);
              // Divide by zero keeps an all-ones quotient regardless of sign.
              r_neg_main <= (w_a_neg ^ w_b_neg) && !(w_div_op && (b_i == '0));
              r_neg_rem  <= w_div_op && w_a_neg;
            end else begin
              out_valid <= 1'b1;
              y_o       <= w_is_alu ? w_alu_y : '0;
              illegal_o <= !w_is_alu;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_MULDIV: begin
          r_cnt <= r_cnt + c_shamt_w'(1);
          if (r_is_div) begin
            if (!w_div_diff[XLEN]) begin
              r_hi <= w_div_diff[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
              r_hi <= w_div_shift[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            {r_hi, r_lo} <= {w_mul_acc, r_lo[XLEN-1:1]};
          end
        end
        ST_DONE: begin
          y_o       <= w_md_y;
          illegal_o <= 1'b0;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
